// File: rtl/im_arbiter.sv
// Instruction-memory arbiter: shares one synchronous IM port between the boot loader
// (write-only) and instruction fetch (read-only), gating fetch until boot completes.
module im_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic        clk,
  input  logic        reset,
  // Fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // Loader port
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_last,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic        ld_err,
  // IM port
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        booted
);

  localparam int unsigned StreakW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_MAX);
  localparam logic [32:0] Span = 33'(DEPTH) << 2;

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e             state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               if_rvalid_q, if_err_q, ld_done_q, ld_err_q, booted_q;

  logic [32:0] if_off, ld_off;
  logic        if_legal, ld_legal;

  // Offsets are one bit wider so addresses below BASE_ADDR wrap to huge values and fail Span.
  always_comb begin
    if_off   = {1'b0, if_addr} - {1'b0, BASE_ADDR};
    ld_off   = {1'b0, ld_addr} - {1'b0, BASE_ADDR};
    if_legal = (if_addr[1:0] == 2'b00) && (if_off < Span);
    ld_legal = (ld_addr[1:0] == 2'b00) && (ld_off < Span);
  end

  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!reset) begin
      if (state_q == StBoot) begin
        ld_gnt = ld_req;
      end else if (if_req && ld_req) begin
        if (streak_q == StreakMax) if_gnt = 1'b1;
        else                       ld_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        ld_gnt = ld_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = ld_wdata;
    if (ld_gnt) begin
      mem_addr = ld_off[13:2];
      mem_we   = ld_legal;
    end else if (if_gnt) begin
      mem_addr = if_off[13:2];
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (ld_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + 1'b1;
    end
    state_d = state_q;
    // The last boot word ends BOOT even when its address faults.
    if (ld_gnt && ld_last) state_d = StRun;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StBoot;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      booted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      if_rvalid_q <= if_gnt;
      if_err_q    <= if_gnt & ~if_legal;
      ld_done_q   <= ld_gnt;
      ld_err_q    <= ld_gnt & ~ld_legal;
      booted_q    <= (state_d == StRun);
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = (if_rvalid_q && !if_err_q) ? mem_rdata : '0;
  assign ld_done   = ld_done_q;
  assign ld_err    = ld_err_q;
  assign booted    = booted_q;

endmodule

// File: tb/tb_im_arbiter.sv
// Directed plus random bench for im_arbiter against a transaction-level reference model.
module tb_im_arbiter;

  localparam int unsigned StarveMax = 4;
  localparam logic [31:0] BaseAddr  = 32'h0000_3000;
  localparam int unsigned Depth     = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ld_req, ld_last, ld_gnt, ld_done, ld_err;
  logic [31:0] ld_addr, ld_wdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        booted;

  logic [31:0] ram [Depth];

  im_arbiter #(
    .STARVE_MAX(StarveMax),
    .BASE_ADDR (BaseAddr),
    .DEPTH     (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_last  (ld_last),
    .ld_gnt   (ld_gnt),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .booted   (booted)
  );

  always #5 clk = ~clk;

  // Synchronous read-first IM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  logic [31:0] ref_mem [logic [31:0]];
  bit          m_booted;
  int          m_streak;
  bit          p_rv, p_ie, p_ld, p_le;
  logic [31:0] p_rd;
  bit          g_if, g_ld;
  logic        s_if, s_ld;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    if (a < BaseAddr) return 1'b0;
    return (a[1:0] == 2'b00) && ((a - BaseAddr) < 4 * Depth);
  endfunction

  function automatic logic [11:0] word(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BaseAddr) >> 2;
    return w[11:0];
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // One clock: check at negedge against the model, advance the model, return at posedge+1.
  task automatic step();
    bit li, ll, eif, eld;
    @(negedge clk);
    if (reset) begin
      m_booted = 1'b0;
      m_streak = 0;
      {p_rv, p_ie, p_ld, p_le} = '0;
      p_rd = '0;
    end
    li  = legal(if_addr);
    ll  = legal(ld_addr);
    eif = 1'b0;
    eld = 1'b0;
    if (!reset) begin
      if (!m_booted) eld = ld_req;
      else if (if_req && ld_req) begin
        if (m_streak == StarveMax) eif = 1'b1;
        else                       eld = 1'b1;
      end else begin
        eif = if_req;
        eld = ld_req;
      end
    end
    s_if = if_gnt;
    s_ld = ld_gnt;
    chk("if_gnt", 32'(if_gnt), 32'(eif));
    chk("ld_gnt", 32'(ld_gnt), 32'(eld));
    chk("mem_we", 32'(mem_we), 32'(eld && ll));
    if (eld && ll) begin
      chk("mem_addr_wr", 32'(mem_addr), 32'(word(ld_addr)));
      chk("mem_wdata", mem_wdata, ld_wdata);
    end else if (eif && li) begin
      chk("mem_addr_rd", 32'(mem_addr), 32'(word(if_addr)));
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(p_rv));
    chk("if_err", 32'(if_err), 32'(p_ie));
    if (p_rv) chk("if_rdata", if_rdata, p_rd);
    chk("ld_done", 32'(ld_done), 32'(p_ld));
    chk("ld_err", 32'(ld_err), 32'(p_le));
    chk("booted", 32'(booted), 32'(m_booted));
    p_rv = eif;
    p_ie = eif && !li;
    p_rd = (eif && li) ? mem_read(if_addr) : 32'h0;
    p_ld = eld;
    p_le = eld && !ll;
    if (eld && ll) ref_mem[ld_addr] = ld_wdata;
    if (eld && ld_last) m_booted = 1'b1;
    if (!reset) begin
      if (!if_req || eif) m_streak = 0;
      else if (eld && m_streak < StarveMax) m_streak++;
    end
    g_if = eif;
    g_ld = eld;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BaseAddr - 32'd4;
      1:       return BaseAddr + 32'(4 * Depth);
      2:       return BaseAddr + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      3:       return BaseAddr + 32'(4 * (Depth - 1));
      default: return BaseAddr + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < int'(Depth); i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
    reset = 1'b1;
    // Requests during reset must not be granted
    if_req = 1'b1; if_addr = 32'h3000;
    ld_req = 1'b1; ld_addr = 32'h3000; ld_wdata = 32'h1111_1111; ld_last = 1'b1;
    repeat (3) step();

    // Boot: fetch held off for 10 cycles
    reset = 1'b0; ld_req = 1'b0; ld_last = 1'b0;
    repeat (10) step();
    chk("boot_not_booted", 32'(booted), 32'd0);

    ld_req = 1'b1; ld_addr = 32'h4180; ld_wdata = 32'hDEAD_BEEF;
    step();
    chk("handler_mem_addr", 32'(mem_addr), 32'd1120);
    chk("handler_mem_we", 32'(mem_we), 32'd1);

    ld_addr = 32'h3000; ld_wdata = 32'h2408_0001; ld_last = 1'b1;
    step();
    chk("boot_ld_done", 32'(ld_done), 32'd1);
    chk("boot_booted", 32'(booted), 32'd1);

    ld_req = 1'b0; ld_last = 1'b0;
    step();
    chk("boot_fetch_rvalid", 32'(if_rvalid), 32'd1);
    chk("boot_fetch_rdata", if_rdata, 32'h2408_0001);

    // Fault cases
    if_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h3002;
    step();
    chk("unaligned_err", 32'(if_err), 32'd1);
    chk("unaligned_rdata", if_rdata, 32'h0);
    if_addr = 32'h7000;
    step();
    chk("above_err", 32'(if_err), 32'd1);
    if_req = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h2FFC; ld_wdata = 32'hBAD0_BAD0;
    step();
    chk("below_ld_err", 32'(ld_err), 32'd1);
    ld_req = 1'b0;
    step();

    // Write then read the next cycle
    ld_req = 1'b1; ld_addr = 32'h3010; ld_wdata = 32'h1234_5678;
    step();
    ld_req = 1'b0; if_req = 1'b1; if_addr = 32'h3010;
    step();
    chk("wr_rd_rdata", if_rdata, 32'h1234_5678);
    if_req = 1'b0;
    step();

    // Starvation: L,L,L,L,F repeating
    if_req = 1'b1; if_addr = 32'h3000;
    ld_req = 1'b1; ld_addr = 32'h3020; ld_wdata = 32'h0BAD_F00D;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("starve_ld", 32'(s_ld), 32'((i % 5) != 4));
      chk("starve_one", 32'(s_if) + 32'(s_ld), 32'd1);
    end
    if_req = 1'b0; ld_req = 1'b0;
    step();

    // Reset the cycle after a fetch grant: the response is dropped
    if_req = 1'b1; if_addr = 32'h3000;
    step();
    reset = 1'b1; if_req = 1'b0;
    step();
    chk("rst_no_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_booted", 32'(booted), 32'd0);
    step();
    reset = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h3004; ld_wdata = 32'hCAFE_0004; ld_last = 1'b1;
    step();
    ld_req = 1'b0; ld_last = 1'b0;
    step();

    // Random traffic with requesters holding until granted
    for (int c = 0; c < 400; c++) begin
      if (g_if || !if_req) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = rand_addr();
      end
      if (g_ld || !ld_req) begin
        ld_req   = ($urandom_range(0, 2) == 0);
        ld_addr  = rand_addr();
        ld_wdata = $urandom();
        ld_last  = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
